fetch_if_id: RTL
================

# fetch_if_id

Instruction fetch stage and IF/ID pipeline register for the 16-bit WISC core. Holds the PC and issues word reads to a stallable instruction memory. Registers each returned instruction with its PC+2 into the IF/ID latch, whose `if_id_inst` drives the decode-stage immediate extender and register-file addressing. Handles decode back-pressure with a one-entry skid buffer, redirects from branch/jump resolution, and stops fetching on HALT.

## Interface
- `N`, 16: datapath / instruction width.
- `RESET_PC`, 16'h0000: PC value after reset.
- `NOP_INST`, 16'h0800: instruction value presented when IF/ID is empty.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset; one clock, asynchronous, active-low.
- `imem_addr` out N: fetch address; always equals `pc`.
- `imem_rd` out 1: read request; combinational from state.
- `imem_data` in N: instruction word; valid only when `imem_done`=1.
- `imem_done` in 1: read complete this cycle for the current `imem_addr`.
- `redirect` in 1: taken branch/jump from the execute stage.
- `redirect_pc` in N: new PC when `redirect`=1.
- `id_stall` in 1: decode cannot accept; IF/ID must hold.
- `if_id_inst` out N: registered instruction to decode.
- `if_id_pc_inc` out N: registered PC+2 of that instruction.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `fetch_halted` out 1: HALT fetched; fetching stopped.

## Operation
- State machine: FETCH, HOLD, HALTED.
- FETCH:
  - `imem_rd`=1; `imem_addr`=`pc`, held stable until `imem_done`.
  - On `imem_done` with the IF/ID slot free (`!if_id_valid` or `!id_stall`): load IF/ID with `imem_data`, `pc+2`, and valid=1. Then `pc`<=`pc+2`.
  - On `imem_done` with the slot occupied (`if_id_valid` & `id_stall`): capture data and `pc+2` into the skid register, set `pc`<=`pc+2`, and go to HOLD.
- HOLD:
  - `imem_rd`=0.
  - When `id_stall`=0: move the skid register into IF/ID with valid=1, then go to FETCH (or HALTED if the skid word is HALT).
- HALTED:
  - `imem_rd`=0 and `fetch_halted`=1.
  - Exits only via `redirect`.
- HALT detection: opcode `inst[15:11]`==5'b00000 on the word entering IF/ID or skid. That word is still delivered with valid=1. Next state is HALTED; no further requests.
- IF/ID drain: if `if_id_valid` & `!id_stall` and no new word loads this cycle, `if_id_valid`<=0 and `if_id_inst`<=`NOP_INST`.
- Redirect (highest priority, any state):
  - `pc`<=`redirect_pc`; IF/ID valid<=0, inst<=`NOP_INST`; skid discarded; `fetch_halted`<=0; next state FETCH.
  - A simultaneous `imem_done` is dropped.
  - Redirect overrides `id_stall`.
- Memory contract: changing `imem_addr` or dropping `imem_rd` aborts the outstanding read. `imem_done` always refers to the address in that same cycle.
- Arithmetic: `pc+2` is modulo 2^N; 16'hFFFE wraps to 16'h0000.

## Timing
- Reset values: `pc`=`RESET_PC`, state FETCH, `if_id_valid`=0, `if_id_inst`=`NOP_INST`, `if_id_pc_inc`=0, `fetch_halted`=0, skid cleared.
- `imem_rd`: 0 while `rst_n`=0; 1 in the first cycle after release.
- Latency: `imem_done` in cycle t gives `if_id_valid`=1 with that word at cycle t+1.
- Throughput: with single-cycle memory (`imem_done` tied 1) and no stalls, one instruction per cycle.
- A word captured into skid at t reaches IF/ID on the first edge where `id_stall`=0. No fetch is issued while in HOLD.
- Reset asserted mid-request or in HOLD: all state returns to reset values immediately (asynchronous); the in-flight word is lost.

## Test plan
- Reset then single-cycle memory returning 0x1234, 0x5678 at 0x0000/0x0002 → IF/ID shows 0x1234/pc_inc 0x0002, then 0x5678/0x0004, on consecutive cycles.
- Memory with 3-cycle `imem_done` delay → `imem_addr` held stable three cycles; `if_id_valid` pulses one cycle per word; `if_id_inst`=0x0800 between words.
- `id_stall`=1 for 4 cycles with IF/ID full and next word 0xA5A5 arriving → state HOLD, `imem_rd`=0, IF/ID unchanged. On stall release, IF/ID=0xA5A5, then fetch resumes at the correct PC.
- `redirect`=1 to 0x0100 coincident with `imem_done` and `id_stall`=1 → next cycle `if_id_valid`=0 and `imem_addr`=0x0100; the dropped word never appears.
- Fetch of 0x0000 (HALT) → delivered with valid=1, `fetch_halted`=1, and `imem_rd`=0 indefinitely. A later redirect to 0x0040 resumes fetching there.
- PC at 0xFFFE → next `imem_addr`=0x0000; `if_id_pc_inc`=0x0000. Assert `rst_n`=0 mid-wait → outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/fetch_if_id.sv
// Instruction fetch stage and IF/ID pipeline register for the 16-bit WISC core.
// Issues word reads to a stallable imem, absorbs decode back-pressure in a one-entry skid, stops on HALT.
module fetch_if_id #(
  parameter int             N        = 16,
  parameter logic [N-1:0]   RESET_PC = 16'h0000,
  parameter logic [N-1:0]   NOP_INST = 16'h0800
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [N-1:0] imem_addr,
  output logic         imem_rd,
  input  logic [N-1:0] imem_data,
  input  logic         imem_done,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  input  logic         id_stall,
  output logic [N-1:0] if_id_inst,
  output logic [N-1:0] if_id_pc_inc,
  output logic         if_id_valid,
  output logic         fetch_halted
);

  typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

  state_t       state;
  logic [N-1:0] pc;
  logic [N-1:0] pc_inc;
  logic [N-1:0] skid_inst;
  logic [N-1:0] skid_pc_inc;
  logic         slot_free;

  function automatic logic is_halt(input logic [N-1:0] inst);
    return inst[N-1 -: 5] == 5'b00000;
  endfunction

  assign pc_inc    = pc + N'(2);
  assign slot_free = !if_id_valid || !id_stall;
  assign imem_addr = pc;
  // NOTE: gating with rst_n keeps the request low during reset even though state already reads FETCH.
  assign imem_rd   = rst_n && (state == FETCH);

  // NOTE: all state here uses non-blocking assignments so every branch sees the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      if_id_inst   <= NOP_INST;
      if_id_pc_inc <= '0;
      if_id_valid  <= 1'b0;
      fetch_halted <= 1'b0;
      skid_inst    <= '0;
      skid_pc_inc  <= '0;
    end else if (redirect) begin
      // Redirect wins over stalls and any word returning this cycle.
      state        <= FETCH;
      pc           <= redirect_pc;
      if_id_inst   <= NOP_INST;
      if_id_valid  <= 1'b0;
      fetch_halted <= 1'b0;
      skid_inst    <= '0;
      skid_pc_inc  <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_done && slot_free) begin
            if_id_inst   <= imem_data;
            if_id_pc_inc <= pc_inc;
            if_id_valid  <= 1'b1;
            pc           <= pc_inc;
            if (is_halt(imem_data)) begin
              state        <= HALTED;
              fetch_halted <= 1'b1;
            end
          end else if (imem_done) begin
            skid_inst   <= imem_data;
            skid_pc_inc <= pc_inc;
            pc          <= pc_inc;
            state       <= HOLD;
          end else if (if_id_valid && !id_stall) begin
            if_id_valid <= 1'b0;
            if_id_inst  <= NOP_INST;
          end
        end

        HOLD: begin
          if (!id_stall) begin
            if_id_inst   <= skid_inst;
            if_id_pc_inc <= skid_pc_inc;
            if_id_valid  <= 1'b1;
            if (is_halt(skid_inst)) begin
              state        <= HALTED;
              fetch_halted <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end

        HALTED: begin
          if (if_id_valid && !id_stall) begin
            if_id_valid <= 1'b0;
            if_id_inst  <= NOP_INST;
          end
        end

        default: state <= FETCH;
      endcase
    end
  end

endmodule
